// File: rtl/store_unit_pkg.sv
// Shared store/load-path definitions: funct3 encodings, store FSM states and
// the byte-size mask helper.
package store_unit_pkg;

   localparam logic [2:0] F3_SB = 3'b000;
   localparam logic [2:0] F3_SH = 3'b001;
   localparam logic [2:0] F3_SW = 3'b010;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BEAT0 = 2'd1,
      ST_BEAT1 = 2'd2
   } state_t;

   // An all-zero mask marks an illegal funct3.
   function automatic logic [3:0] size_mask(input logic [2:0] funct3);
      case (funct3)
         F3_SB:   return 4'b0001;
         F3_SH:   return 4'b0011;
         F3_SW:   return 4'b1111;
         default: return 4'b0000;
      endcase
   endfunction

endpackage

// File: rtl/store_unit_align.sv
// Combinational store alignment: narrows store data to its size and shifts
// data and strobes into an 8-byte window spanning two bus words.
module store_align
   import store_unit_pkg::*;
(
   input  logic [2:0]  i_funct3,
   input  logic [1:0]  i_offset,
   input  logic [31:0] i_data,
   output logic [63:0] o_data_win,
   output logic [7:0]  o_strb_win,
   output logic        o_illegal,
   output logic        o_misaligned
);

   logic [3:0]  w_mask;
   logic [31:0] w_bytes;

   assign w_mask  = size_mask(i_funct3);
   assign w_bytes = i_data & {{8{w_mask[3]}}, {8{w_mask[2]}}, {8{w_mask[1]}}, {8{w_mask[0]}}};

   assign o_data_win = {32'h0, w_bytes} << {i_offset, 3'b000};
   assign o_strb_win = {4'h0, w_mask} << i_offset;

   assign o_illegal    = (w_mask == 4'b0000);
   assign o_misaligned = ((i_funct3 == F3_SH) && i_offset[0]) ||
                         ((i_funct3 == F3_SW) && (i_offset != 2'b00));

endmodule

// File: rtl/store_unit.sv
// Store path: accepts one request, issues one or two aligned write beats
// (two when the store straddles a word) and pulses done/err on retirement.
module store_unit
   import store_unit_pkg::*;
#(
   parameter bit ALLOW_MISALIGNED = 1'b1,
   parameter int ADDR_W           = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_data,
   input  logic [2:0]        req_funct3,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [3:0]        mem_wstrb,
   input  logic              mem_ack,
   output logic              done,
   output logic              err
);

   state_t            r_state;
   logic              r_mem_req;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [31:0]       r_mem_wdata;
   logic [3:0]        r_mem_wstrb;
   logic              r_need_b1;
   logic [ADDR_W-1:0] r_b1_addr;
   logic [31:0]       r_b1_data;
   logic [3:0]        r_b1_strb;
   logic              r_done;
   logic              r_err;

   logic [63:0]       w_data_win;
   logic [7:0]        w_strb_win;
   logic              w_illegal;
   logic              w_misaligned;
   logic              w_reject;
   logic [ADDR_W-1:0] w_base;

   store_align u_align (
      .i_funct3     (req_funct3),
      .i_offset     (req_addr[1:0]),
      .i_data       (req_data),
      .o_data_win   (w_data_win),
      .o_strb_win   (w_strb_win),
      .o_illegal    (w_illegal),
      .o_misaligned (w_misaligned)
   );

   assign w_reject = w_illegal || (w_misaligned && !ALLOW_MISALIGNED);
   assign w_base   = {req_addr[ADDR_W-1:2], 2'b00};

   // NOTE: ready decodes straight from the state register so the async reset
   // raises it at once.
   assign req_ready = (r_state == ST_IDLE);
   assign mem_req   = r_mem_req;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign mem_wstrb = r_mem_wstrb;
   assign done      = r_done;
   assign err       = r_err;

   // NOTE: every state register uses non-blocking assignment so all of them
   // update together on the edge, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_mem_req   <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_wstrb <= '0;
         r_need_b1   <= 1'b0;
         r_b1_addr   <= '0;
         r_b1_data   <= '0;
         r_b1_strb   <= '0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (req_valid) begin
                  if (w_reject) begin
                     r_done <= 1'b1;
                     r_err  <= 1'b1;
                  end else begin
                     r_mem_req   <= 1'b1;
                     r_mem_addr  <= w_base;
                     r_mem_wdata <= w_data_win[31:0];
                     r_mem_wstrb <= w_strb_win[3:0];
                     r_need_b1   <= |w_strb_win[7:4];
                     r_b1_addr   <= w_base + ADDR_W'(4);
                     r_b1_data   <= w_data_win[63:32];
                     r_b1_strb   <= w_strb_win[7:4];
                     r_state     <= ST_BEAT0;
                  end
               end
            end
            ST_BEAT0: begin
               if (mem_ack) begin
                  if (r_need_b1) begin
                     r_mem_addr  <= r_b1_addr;
                     r_mem_wdata <= r_b1_data;
                     r_mem_wstrb <= r_b1_strb;
                     r_state     <= ST_BEAT1;
                  end else begin
                     r_mem_req   <= 1'b0;
                     r_mem_addr  <= '0;
                     r_mem_wdata <= '0;
                     r_mem_wstrb <= '0;
                     r_done      <= 1'b1;
                     r_state     <= ST_IDLE;
                  end
               end
            end
            ST_BEAT1: begin
               if (mem_ack) begin
                  r_mem_req   <= 1'b0;
                  r_mem_addr  <= '0;
                  r_mem_wdata <= '0;
                  r_mem_wstrb <= '0;
                  r_done      <= 1'b1;
                  r_state     <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_store_unit.sv
// Self-checking bench for store_unit: directed stores, random stores against
// a byte-window model, rejection on a strict instance, and mid-transfer reset.
module tb_store_unit;
   import store_unit_pkg::*;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_valid_s;
   logic [31:0] req_addr, req_data;
   logic [2:0]  req_funct3;
   logic        mem_ack;

   logic        req_ready, mem_req, done, err;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        req_ready_s, mem_req_s, done_s, err_s;
   logic [31:0] mem_addr_s, mem_wdata_s;
   logic [3:0]  mem_wstrb_s;

   beat_t sb_q[$];
   int    checks = 0;
   int    errors = 0;

   always #5 clk = ~clk;

   store_unit #(.ALLOW_MISALIGNED(1'b1), .ADDR_W(32)) u_dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_data(req_data), .req_funct3(req_funct3),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .done(done), .err(err)
   );

   store_unit #(.ALLOW_MISALIGNED(1'b0), .ADDR_W(32)) u_dut_strict (
      .clk(clk), .rst(rst), .req_valid(req_valid_s), .req_ready(req_ready_s),
      .req_addr(req_addr), .req_data(req_data), .req_funct3(req_funct3),
      .mem_req(mem_req_s), .mem_addr(mem_addr_s), .mem_wdata(mem_wdata_s),
      .mem_wstrb(mem_wstrb_s), .mem_ack(mem_ack), .done(done_s), .err(err_s)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_beat(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      beat_t b;
      b.addr = a; b.data = d; b.strb = s;
      sb_q.push_back(b);
   endtask

   // Byte-lane reference: place each store byte at its own byte address.
   task automatic push_model(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data);
      int          nbytes;
      logic [31:0] base;
      logic [31:0] w0, w1;
      logic [3:0]  s0, s1;
      logic [7:0]  byte_v;
      int          lane;
      nbytes = (f3 == F3_SB) ? 1 : (f3 == F3_SH) ? 2 : 4;
      base = addr & 32'hFFFF_FFFC;
      w0 = '0; w1 = '0; s0 = '0; s1 = '0;
      for (int k = 0; k < nbytes; k++) begin
         byte_v = data[8*k +: 8];
         lane   = int'(addr[1:0]) + k;
         if (lane < 4) begin
            w0[8*lane +: 8] = byte_v;
            s0[lane] = 1'b1;
         end else begin
            w1[8*(lane-4) +: 8] = byte_v;
            s1[lane-4] = 1'b1;
         end
      end
      push_beat(base, w0, s0);
      if (s1 != 4'b0000) push_beat(base + 32'd4, w1, s1);
   endtask

   // Drives one legal store on u_dut and retires every queued beat in order.
   task automatic run_store(input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] data, input int stall);
      int    nb;
      beat_t b;
      nb = sb_q.size();
      check("ready_before_accept", req_ready, 1);
      req_valid = 1'b1; req_funct3 = f3; req_addr = addr; req_data = data;
      tick();
      req_valid = 1'b0; req_funct3 = 3'b111; req_addr = ~addr; req_data = ~data;
      check("ready_busy", req_ready, 0);
      for (int i = 0; i < nb; i++) begin
         b = sb_q.pop_front();
         for (int s = 0; s <= stall; s++) begin
            check("mem_req", mem_req, 1);
            check("mem_addr", mem_addr, b.addr);
            check("mem_wdata", mem_wdata, b.data);
            check("mem_wstrb", mem_wstrb, b.strb);
            check("done_early", done, 0);
            if (s == stall) mem_ack = 1'b1;
            tick();
            mem_ack = 1'b0;
         end
      end
      check("done_pulse", done, 1);
      check("err_clear", err, 0);
      check("mem_req_drop", mem_req, 0);
      check("ready_in_done", req_ready, 1);
   endtask

   initial begin
      logic [2:0]  f3_r;
      logic [31:0] a_r, d_r;
      int          st_r;

      rst = 1'b1; req_valid = 1'b0; req_valid_s = 1'b0; mem_ack = 1'b0;
      req_addr = '0; req_data = '0; req_funct3 = '0;
      tick();
      check("rst_ready", req_ready, 1);
      check("rst_mem_req", mem_req, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_mem_wstrb", mem_wstrb, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      tick();
      rst = 1'b0;
      tick();

      // Stray ack in IDLE must be ignored.
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      check("stray_ack_req", mem_req, 0);
      check("stray_ack_done", done, 0);
      check("stray_ack_ready", req_ready, 1);

      push_beat(32'h0000_1000, 32'hDEAD_BEEF, 4'b1111);
      run_store(F3_SW, 32'h0000_1000, 32'hDEAD_BEEF, 0);

      push_beat(32'h0000_1000, 32'hAB00_0000, 4'b1000);
      run_store(F3_SB, 32'h0000_1003, 32'h1234_56AB, 0);

      push_beat(32'h0000_1000, 32'hFE00_0000, 4'b1000);
      push_beat(32'h0000_1004, 32'h0000_00CA, 4'b0001);
      run_store(F3_SH, 32'h0000_1003, 32'h0000_CAFE, 0);

      push_beat(32'hFFFF_FFFC, 32'h3344_0000, 4'b1100);
      push_beat(32'h0000_0000, 32'h0000_1122, 4'b0011);
      run_store(F3_SW, 32'hFFFF_FFFE, 32'h1122_3344, 3);

      // Illegal funct3 on the permissive instance.
      req_valid = 1'b1; req_funct3 = 3'b011; req_addr = 32'h0000_2000; req_data = 32'h5555_AAAA;
      tick();
      req_valid = 1'b0;
      check("ill_done", done, 1);
      check("ill_err", err, 1);
      check("ill_mem_req", mem_req, 0);
      tick();
      check("ill_done_clear", done, 0);
      check("ill_err_clear", err, 0);
      check("ill_mem_req_after", mem_req, 0);

      // Misaligned word rejected by the strict instance.
      req_valid_s = 1'b1; req_funct3 = F3_SW; req_addr = 32'h0000_1001; req_data = 32'h0BAD_F00D;
      tick();
      req_valid_s = 1'b0;
      check("mis_done", done_s, 1);
      check("mis_err", err_s, 1);
      check("mis_mem_req", mem_req_s, 0);
      check("mis_ready", req_ready_s, 1);
      tick();
      check("mis_done_clear", done_s, 0);
      check("mis_mem_req_after", mem_req_s, 0);

      // A byte store at any offset is still legal on the strict instance.
      req_valid_s = 1'b1; req_funct3 = F3_SB; req_addr = 32'h0000_3001; req_data = 32'hFFFF_FF77;
      tick();
      req_valid_s = 1'b0;
      check("strict_sb_req", mem_req_s, 1);
      check("strict_sb_addr", mem_addr_s, 32'h0000_3000);
      check("strict_sb_wdata", mem_wdata_s, 32'h0000_7700);
      check("strict_sb_wstrb", mem_wstrb_s, 4'b0010);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      check("strict_sb_done", done_s, 1);
      check("strict_sb_err", err_s, 0);

      // Random legal stores against the byte-lane model.
      for (int n = 0; n < 10; n++) begin
         f3_r = 3'($urandom_range(0, 2));
         a_r  = $urandom();
         d_r  = $urandom();
         st_r = $urandom_range(0, 2);
         push_model(f3_r, a_r, d_r);
         run_store(f3_r, a_r, d_r, st_r);
      end

      // Reset during BEAT1 abandons the transfer without done.
      push_beat(32'h0000_1000, 32'hFE00_0000, 4'b1000);
      req_valid = 1'b1; req_funct3 = F3_SH; req_addr = 32'h0000_1003; req_data = 32'h0000_CAFE;
      tick();
      req_valid = 1'b0;
      check("rb_beat0_addr", mem_addr, 32'h0000_1000);
      void'(sb_q.pop_front());
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      check("rb_beat1_req", mem_req, 1);
      check("rb_beat1_addr", mem_addr, 32'h0000_1004);
      #2;
      rst = 1'b1;
      #1;
      check("rb_mem_req", mem_req, 0);
      check("rb_ready", req_ready, 1);
      check("rb_mem_addr", mem_addr, 0);
      check("rb_mem_wstrb", mem_wstrb, 0);
      check("rb_done", done, 0);
      tick();
      rst = 1'b0;
      tick();
      check("rb_no_done", done, 0);
      check("rb_idle_req", mem_req, 0);

      push_beat(32'h0000_4000, 32'h0099_0000, 4'b0100);
      run_store(F3_SB, 32'h0000_4002, 32'hABCD_EF99, 1);

      check("sb_q_empty", sb_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/store_unit.md
# store_unit

Store-path counterpart to the load-side sign extender: takes a store request from the execute/memory stage, narrows the store data to byte/half/word, aligns it onto a 32-bit word bus with byte strobes, and issues one or two bus write beats. A misaligned store is split into two beats when it straddles a word boundary. The block sits between the pipeline's memory stage and the data-memory write port, and stalls the pipeline through a valid/ready handshake.

## Interface
- ALLOW_MISALIGNED, 1: 1 splits straddling stores into two beats; 0 rejects any misaligned store with `err`.
- ADDR_W, 32: byte-address width.

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  store request present
- req_ready  out  1  block can accept a request (high only in IDLE)
- req_addr  in  ADDR_W  byte address
- req_data  in  32  rs2 value, unaligned
- req_funct3  in  3  000 SB, 001 SH, 010 SW; all others illegal
- mem_req  out  1  bus write beat valid
- mem_addr  out  ADDR_W  word-aligned beat address (bits [1:0] = 0)
- mem_wdata  out  32  aligned write data
- mem_wstrb  out  4  byte enables
- mem_ack  in  1  beat accepted this cycle
- done  out  1  one-cycle pulse: request retired
- err  out  1  one-cycle pulse with `done`: request rejected, no bus write

## Operation
- States: IDLE, BEAT0, BEAT1.
- Handshake: request accepted when `req_valid && req_ready`; inputs are registered, so the caller may change them the following cycle.
- size_mask: SB 0001, SH 0011, SW 1111; offset = `req_addr[1:0]`.
- 8-bit strobe window = size_mask << offset; 64-bit data window = (req_data truncated to size) << (8*offset). Bytes outside the store size are zero in `mem_wdata`.
- Beat0: addr = req_addr & ~3, strobe = window[3:0], data = window[31:0].
- Beat1 is needed when window[7:4] != 0: addr = (req_addr & ~3) + 4 (wraps modulo 2^ADDR_W, so 0xFFFFFFFC gives 0x00000000), strobe = window[7:4], data = window[63:32].
- Illegal funct3, or a misaligned store with ALLOW_MISALIGNED=0 (SH with offset[0]=1, SW with offset != 0): no bus beat; `done` and `err` pulse.
- Transitions:
  - IDLE → BEAT0 on accept of a legal request.
  - BEAT0 → BEAT1 on `mem_ack` if beat1 is needed.
  - BEAT0 → IDLE on `mem_ack` otherwise.
  - BEAT1 → IDLE on `mem_ack`.
  - Rejected requests stay in IDLE.
- `done` is registered: it pulses the cycle after the final ack, or the cycle after accept for a rejected request.
- `done` and `err` are never high without a prior accept.

## Timing
- Reset values: state IDLE, `req_ready` 1, `mem_req` 0, `mem_addr` 0, `mem_wdata` 0, `mem_wstrb` 0, `done` 0, `err` 0.
- Accept at cycle T → `mem_req` high at T+1.
- Aligned store with ack at T+1 → `done` at T+2.
- Split store with acks at T+1 and T+2 → beat1 on bus at T+2, `done` at T+3.
- Rejected store → `done` and `err` at T+1, `mem_req` never rises.
- `mem_req`, `mem_addr`, `mem_wdata` and `mem_wstrb` are held stable until `mem_ack`. There is no gap cycle between beat0 ack and beat1.
- `req_ready` is low from the cycle after accept until the state returns to IDLE. It is high in the `done` cycle, so back-to-back acceptance is allowed.
- `mem_ack` while `mem_req` is low is ignored.
- Reset mid-transfer: all outputs return to reset values immediately (asynchronous); any pending beat is abandoned with no `done`.

## Structure
- Shared package: funct3 constants (`F3_SB`, `F3_SH`, `F3_SW`) and state encoding; the load path reuses the funct3 constants.
- One sub-module, `store_align`: combinational logic taking (funct3, offset, data) and producing the 64-bit data window, the 8-bit strobe window, and `illegal`/`misaligned` flags. The FSM and output registers live in `store_unit`.

## Test plan
- SW addr 0x1000, data 0xDEADBEEF, ack at T+1 → one beat: addr 0x1000, wstrb 1111, wdata 0xDEADBEEF; `done` at T+2.
- SB addr 0x1003, data 0x123456AB → addr 0x1000, wstrb 1000, wdata 0xAB000000; one beat.
- SH addr 0x1003, data 0x0000CAFE (ALLOW_MISALIGNED=1) → beat0: 0x1000, wstrb 1000, wdata 0xFE000000; beat1: 0x1004, wstrb 0001, wdata 0x000000CA.
- SW addr 0xFFFFFFFE, data 0x11223344 → beat1 address wraps to 0x00000000 with wstrb 0011, wdata 0x00001122; `mem_ack` held low 3 cycles → beat outputs stay stable until ack.
- funct3 011, or SW addr 0x1001 with ALLOW_MISALIGNED=0 → `done` and `err` at T+1, `mem_req` stays 0.
- Assert `rst` during BEAT1 → `mem_req` 0 and `req_ready` 1 immediately, no `done`; a new SB accepted after reset completes normally.
